coreahblite_slavearbiter_rr: RTL

//  Per-slave arbiter for the CoreAHBLite matrix, generalised to NUM_MASTERS masters (was fixed at 4).

---
 rtl/coreahblite_arb_pkg.sv | 19 +
 rtl/coreahblite_rr_picker.sv | 31 +++
 rtl/coreahblite_slavearbiter_rr.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/coreahblite_arb_pkg.sv
// Shared definitions for the CoreAHBLite per-slave round-robin arbiter:
// state encodings, master-count limit and owner-index width derivation.
package coreahblite_arb_pkg;

    localparam int MAX_MASTERS = 16;

    typedef enum logic [1:0] {
        ST_DONE       = 2'd0,
        ST_EXTEND     = 2'd1,
        ST_LOCK       = 2'd2,
        ST_LOCKEXTEND = 2'd3
    } arb_st_e;

    // Owner index width; a single master still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/coreahblite_rr_picker.sv
// Combinational round-robin picker: first set request after 'last',
// scanning upward with wrap, ending at 'last' itself.
module coreahblite_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(last) + k) % N)) begin
                    found = 1'b1;
                    idx   = IW'(j);
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            onehot[j] = found && (idx == IW'(j));
        end
    end

endmodule

// File: rtl/coreahblite_slavearbiter_rr.sv
// Per-slave round-robin address-phase arbiter with locked-transfer hold.
// Optional lock-hold timeout enabled by defining COREAHBLITE_LOCK_TIMEOUT_EN.
module coreahblite_slavearbiter_rr
    import coreahblite_arb_pkg::*;
#(
    parameter int NUM_MASTERS  = 4,
    parameter int LOCK_TIMEOUT = 256,
    localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] MADDRSEL,
    input  logic                   ADDRPHEND,
    input  logic [NUM_MASTERS-1:0] MGATEDHMASTLOCK,
    output logic [NUM_MASTERS-1:0] MASTERADDRINPROG,
    output logic [IDX_W-1:0]       OWNER,
    output logic                   LOCKACTIVE,
    output logic                   LOCKTIMEOUT,
    output logic [1:0]             st_dbg
);

    localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 1 || NUM_MASTERS > MAX_MASTERS ||
        LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 65535) begin : g_param_err
        $error("coreahblite_slavearbiter_rr: illegal parameter value");
    end

    arb_st_e                st, st_n;
    logic [IDX_W-1:0]       owner, owner_n;
    logic [NUM_MASTERS-1:0] owner_oh, grant, pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found, owner_valid, owner_req, owner_lock;
    logic                   lock_timeout_n;

    coreahblite_rr_picker #(.N(NUM_MASTERS), .IW(IDX_W)) u_picker (
        .req    (MADDRSEL),
        .last   (owner),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        owner_oh = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            owner_oh[j] = (owner == IDX_W'(j));
        end
    end

    assign owner_valid = int'(owner) < NUM_MASTERS;
    assign owner_req   = |(MADDRSEL & owner_oh);
    assign owner_lock  = |(MGATEDHMASTLOCK & owner_oh);

`ifdef COREAHBLITE_LOCK_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);
    logic [15:0] lock_cnt, lock_cnt_n;
    logic        timed_out;

    // >= rather than == so a lock whose count ran past the limit while
    // being granted still releases on its next idle cycle.
    assign timed_out = (lock_cnt >= TO_LAST);

    always_comb begin
        lock_cnt_n = lock_cnt;
        if (st == ST_DONE) begin
            lock_cnt_n = '0;
        end else if (st == ST_LOCK && lock_cnt != 16'hFFFF) begin
            lock_cnt_n = lock_cnt + 16'd1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) lock_cnt <= '0;
        else        lock_cnt <= lock_cnt_n;
    end
`endif

    always_comb begin
        st_n           = st;
        owner_n        = owner;
        grant          = '0;
        lock_timeout_n = 1'b0;
        if (!owner_valid) begin
            st_n    = ST_DONE;
            owner_n = OWNER_RST;
        end else begin
            case (st)
                ST_DONE: begin
                    if (pick_found) begin
                        owner_n = pick_idx;
                        if (|(MGATEDHMASTLOCK & pick_oh)) begin
                            st_n = ST_LOCK;
                        end else begin
                            grant = pick_oh;
                            st_n  = ADDRPHEND ? ST_DONE : ST_EXTEND;
                        end
                    end
                end
                ST_EXTEND: begin
                    grant = owner_oh;
                    if (ADDRPHEND) st_n = ST_DONE;
                end
                ST_LOCK: begin
                    if (!owner_lock) begin
                        st_n = ST_DONE;
                    end else if (owner_req) begin
                        grant = owner_oh;
                        st_n  = ADDRPHEND ? ST_LOCK : ST_LOCKEXTEND;
                    end
`ifdef COREAHBLITE_LOCK_TIMEOUT_EN
                    else if (timed_out) begin
                        st_n           = ST_DONE;
                        lock_timeout_n = 1'b1;
                    end
`endif
                end
                ST_LOCKEXTEND: begin
                    grant = owner_oh;
                    if (ADDRPHEND) st_n = ST_LOCK;
                end
                default: begin
                    st_n    = ST_DONE;
                    owner_n = OWNER_RST;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            st          <= ST_DONE;
            owner       <= OWNER_RST;
            LOCKACTIVE  <= 1'b0;
            LOCKTIMEOUT <= 1'b0;
        end else begin
            st          <= st_n;
            owner       <= owner_n;
            LOCKACTIVE  <= (st_n == ST_LOCK) || (st_n == ST_LOCKEXTEND);
            LOCKTIMEOUT <= lock_timeout_n;
        end
    end

    // Grant is combinational; force it off while reset is asserted.
    assign MASTERADDRINPROG = HRESET ? '0 : grant;
    assign OWNER            = owner;
    assign st_dbg           = st;

endmodule
